collatz_range_multi: RTL and testbench

- Next-generation Collatz range engine.
- Computes the iteration count for RAM_WORDS consecutive starting values using NCH parallel iteration units, and stores the results in an internal result RAM.
- Tracks the running maximum count and its index, and flags arithmetic overflow.
- Sits behind the board top level. Switch/key logic drives go/start; the HEX displays read results through the rd_addr/rd_data port.

---
 rtl/collatz_range_multi.sv | 211 +++++++++++++++++++++
 tb/tb_collatz_range_multi.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collatz_range_multi.sv
// collatz_range_multi
// Computes Collatz iteration counts for RAM_WORDS consecutive start values.
// NCH units run in parallel. Each batch is loaded in LAUNCH, iterated in RUN,
// and written to the result RAM one unit per cycle in WRITE. The running
// maximum and the overflow flag are updated only while writing.
module collatz_range_multi #(
   parameter int WIDTH     = 32,
   parameter int CW        = 16,
   parameter int RAM_WORDS = 256,
   parameter int ADDR_BITS = 8,
   parameter int NCH       = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 go,
   input  logic [WIDTH-1:0]     start,
   output logic                 busy,
   output logic                 done,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [CW-1:0]        rd_data,
   output logic [CW-1:0]        max_count,
   output logic [ADDR_BITS-1:0] max_index,
   output logic                 ovf
);

   localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;  // write-slot counter width
   localparam int BW = ADDR_BITS + 1;                // base can reach RAM_WORDS

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_RUN,
      S_WRITE,
      S_FINISH
   } state_t;

   state_t r_state, w_next;

   // Control registers
   logic [WIDTH-1:0]     r_start;
   logic [BW-1:0]        r_base;
   logic [KW-1:0]        r_k;
   logic                 r_busy, r_done, r_ovf;
   logic [CW-1:0]        r_max;
   logic [ADDR_BITS-1:0] r_max_idx;
   logic [CW-1:0]        r_rd_data;

   // Per-unit iteration state
   logic [WIDTH-1:0]     r_n   [NCH];
   logic [CW-1:0]        r_cnt [NCH];
   logic [NCH-1:0]       r_fin;
   logic [NCH-1:0]       r_uovf;

   // Result storage
   logic [CW-1:0]        r_ram [RAM_WORDS];

   // Per-unit combinational helpers
   logic [WIDTH-1:0]     w_load    [NCH];
   logic [WIDTH+1:0]     w_tri     [NCH];
   logic [CW-1:0]        w_cnt_inc [NCH];

   logic                 w_all_fin;
   logic                 w_k_last;
   logic                 w_base_last;
   logic [ADDR_BITS-1:0] w_waddr;
   logic [CW-1:0]        w_wcnt;

   assign w_all_fin   = &r_fin;
   assign w_k_last    = (r_k == KW'(NCH - 1));
   assign w_base_last = (r_base == BW'(RAM_WORDS - NCH));
   assign w_waddr     = r_base[ADDR_BITS-1:0] + ADDR_BITS'(r_k);
   assign w_wcnt      = r_cnt[r_k];

   // Per-unit load value, 3n+1 at two extra bits, and saturating count increment
   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         w_load[k]    = r_start + WIDTH'(r_base) + WIDTH'(k);
         w_tri[k]     = {2'b00, r_n[k]} + {1'b0, r_n[k], 1'b0} + (WIDTH+2)'(1);
         w_cnt_inc[k] = (r_cnt[k] == '1) ? r_cnt[k] : r_cnt[k] + CW'(1);
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      // NOTE: default assigned first so every path drives w_next and no latch is inferred
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (go) w_next = S_LAUNCH;
         S_LAUNCH: w_next = S_RUN;
         S_RUN:    if (w_all_fin) w_next = S_WRITE;
         S_WRITE:  if (w_k_last) w_next = w_base_last ? S_FINISH : S_LAUNCH;
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Run control: start latch, batch base, write slot, max tracking, busy/done
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_start   <= '0;
         r_base    <= '0;
         r_k       <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
         r_max     <= '0;
         r_max_idx <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (go) begin
                  r_start   <= start;
                  r_base    <= '0;
                  r_max     <= '0;
                  r_max_idx <= '0;
                  r_ovf     <= 1'b0;
                  r_done    <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end
            S_LAUNCH: r_k <= '0;
            S_WRITE: begin
               // Strict greater-than keeps the lowest index on ties
               if (w_wcnt > r_max) begin
                  r_max     <= w_wcnt;
                  r_max_idx <= w_waddr;
               end
               if (r_uovf[r_k]) r_ovf <= 1'b1;
               if (w_k_last) begin
                  r_k <= '0;
                  if (!w_base_last) r_base <= r_base + BW'(NCH);
               end else begin
                  r_k <= r_k + KW'(1);
               end
            end
            S_FINISH: begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Iteration units: load in LAUNCH, one Collatz step per cycle in RUN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NCH; k++) begin
            r_n[k]   <= '0;
            r_cnt[k] <= '0;
         end
         r_fin  <= '0;
         r_uovf <= '0;
      end else if (r_state == S_LAUNCH) begin
         for (int k = 0; k < NCH; k++) begin
            r_n[k]    <= w_load[k];
            // n=0 has count 0; n=0 and n=1 are finished on load
            r_cnt[k]  <= (w_load[k] == '0) ? '0 : CW'(1);
            r_fin[k]  <= (w_load[k] <= WIDTH'(1));
            r_uovf[k] <= 1'b0;
         end
      end else if (r_state == S_RUN) begin
         for (int k = 0; k < NCH; k++) begin
            if (!r_fin[k]) begin
               if (r_n[k][0]) begin
                  if (w_tri[k][WIDTH+1:WIDTH] != 2'b00) begin
                     // 3n+1 does not fit in WIDTH bits: stop with all-ones count
                     r_fin[k]  <= 1'b1;
                     r_cnt[k]  <= '1;
                     r_uovf[k] <= 1'b1;
                  end else begin
                     r_n[k]   <= w_tri[k][WIDTH-1:0];
                     r_cnt[k] <= w_cnt_inc[k];
                  end
               end else begin
                  r_n[k]   <= r_n[k] >> 1;
                  r_cnt[k] <= w_cnt_inc[k];
                  r_fin[k] <= (r_n[k] == WIDTH'(2));
               end
            end
         end
      end
   end

   // Result RAM write port, one unit per WRITE cycle
   always_ff @(posedge clk) begin
      // NOTE: RAM has no reset so it maps to block memory; contents survive reset
      if (r_state == S_WRITE) r_ram[w_waddr] <= w_wcnt;
   end

   // Registered read port, continuously reading rd_addr
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_rd_data <= '0;
      else       r_rd_data <= r_ram[rd_addr];
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign rd_data   = r_rd_data;
   assign max_count = r_max;
   assign max_index = r_max_idx;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_collatz_range_multi.sv
// Testbench for collatz_range_multi: table-driven checks on several
// parameterisations, protocol sequences, and random runs against a
// plain-arithmetic Collatz reference model.
module tb_collatz_range_multi;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Main instance: WIDTH=32, CW=16, RAM_WORDS=16, NCH=4
   logic        m_go;
   logic [31:0] m_start;
   logic        m_busy, m_done, m_ovf;
   logic [3:0]  m_rd_addr, m_max_index;
   logic [15:0] m_rd_data, m_max_count;

   collatz_range_multi #(.WIDTH(32), .CW(16), .RAM_WORDS(16), .ADDR_BITS(4), .NCH(4)) u_main (
      .clk(clk), .reset(reset), .go(m_go), .start(m_start), .busy(m_busy), .done(m_done),
      .rd_addr(m_rd_addr), .rd_data(m_rd_data), .max_count(m_max_count),
      .max_index(m_max_index), .ovf(m_ovf));

   // Group of small instances sharing go and read index
   logic        g_go;
   logic [7:0]  rd_idx;
   logic [31:0] t_start;
   logic        t_busy [3];
   logic        t_done [3];
   logic        t_ovf  [3];
   logic [15:0] t_rd   [3];
   logic [15:0] t_max  [3];
   logic [1:0]  t_midx [3];

   collatz_range_multi #(.WIDTH(32), .CW(16), .RAM_WORDS(4), .ADDR_BITS(2), .NCH(1)) u_t1 (
      .clk(clk), .reset(reset), .go(g_go), .start(t_start), .busy(t_busy[0]), .done(t_done[0]),
      .rd_addr(rd_idx[1:0]), .rd_data(t_rd[0]), .max_count(t_max[0]), .max_index(t_midx[0]),
      .ovf(t_ovf[0]));
   collatz_range_multi #(.WIDTH(32), .CW(16), .RAM_WORDS(4), .ADDR_BITS(2), .NCH(2)) u_t2 (
      .clk(clk), .reset(reset), .go(g_go), .start(t_start), .busy(t_busy[1]), .done(t_done[1]),
      .rd_addr(rd_idx[1:0]), .rd_data(t_rd[1]), .max_count(t_max[1]), .max_index(t_midx[1]),
      .ovf(t_ovf[1]));
   collatz_range_multi #(.WIDTH(32), .CW(16), .RAM_WORDS(4), .ADDR_BITS(2), .NCH(4)) u_t4 (
      .clk(clk), .reset(reset), .go(g_go), .start(t_start), .busy(t_busy[2]), .done(t_done[2]),
      .rd_addr(rd_idx[1:0]), .rd_data(t_rd[2]), .max_count(t_max[2]), .max_index(t_midx[2]),
      .ovf(t_ovf[2]));

   // 8-bit overflow instance
   logic [7:0]  ov_start;
   logic        ov_busy, ov_done, ov_ovf;
   logic [15:0] ov_rd, ov_max;
   logic [1:0]  ov_midx;
   collatz_range_multi #(.WIDTH(8), .CW(16), .RAM_WORDS(4), .ADDR_BITS(2), .NCH(2)) u_ov (
      .clk(clk), .reset(reset), .go(g_go), .start(ov_start), .busy(ov_busy), .done(ov_done),
      .rd_addr(rd_idx[1:0]), .rd_data(ov_rd), .max_count(ov_max), .max_index(ov_midx),
      .ovf(ov_ovf));

   // 8-bit zero/wrap instance
   logic [7:0]  wr_start;
   logic        wr_busy, wr_done, wr_ovf;
   logic [15:0] wr_rd, wr_max;
   logic [0:0]  wr_midx;
   collatz_range_multi #(.WIDTH(8), .CW(16), .RAM_WORDS(2), .ADDR_BITS(1), .NCH(2)) u_wr (
      .clk(clk), .reset(reset), .go(g_go), .start(wr_start), .busy(wr_busy), .done(wr_done),
      .rd_addr(rd_idx[0:0]), .rd_data(wr_rd), .max_count(wr_max), .max_index(wr_midx),
      .ovf(wr_ovf));

   // 4-bit count saturation instance
   logic [31:0] sat_start;
   logic        sat_busy, sat_done, sat_ovf;
   logic [3:0]  sat_rd, sat_max;
   logic [0:0]  sat_midx;
   collatz_range_multi #(.WIDTH(32), .CW(4), .RAM_WORDS(2), .ADDR_BITS(1), .NCH(2)) u_sat (
      .clk(clk), .reset(reset), .go(g_go), .start(sat_start), .busy(sat_busy), .done(sat_done),
      .rd_addr(rd_idx[0:0]), .rd_data(sat_rd), .max_count(sat_max), .max_index(sat_midx),
      .ovf(sat_ovf));

   // ---------------- reference model ----------------
   typedef struct {
      int cnt;
      bit ovf;
   } mres_t;

   // Walk the sequence with wide arithmetic; overflow when 3n+1 exceeds 2^w-1
   function automatic mres_t ref_count(longint unsigned n, int w, int cw);
      mres_t           r;
      longint unsigned lim;
      int              cmax;
      int              guard;
      lim   = (64'd1 << w) - 1;
      cmax  = (1 << cw) - 1;
      r.cnt = 0;
      r.ovf = 1'b0;
      guard = 0;
      if (n == 0) return r;
      r.cnt = 1;
      while (n != 1 && guard < 100000) begin
         guard++;
         if (n % 2 == 1) begin
            n = 3 * n + 1;
            if (n > lim) begin
               r.cnt = cmax;
               r.ovf = 1'b1;
               return r;
            end
         end else begin
            n = n / 2;
         end
         if (r.cnt < cmax) r.cnt++;
      end
      return r;
   endfunction

   int exp_cnt [16];
   int exp_max;
   int exp_idx;
   int exp_ovf;

   // Fill expected results for a 16-word run of the main instance
   task automatic model_main(input logic [31:0] s);
      mres_t           r;
      logic [31:0]     n;
      exp_max = 0;
      exp_idx = 0;
      exp_ovf = 0;
      for (int i = 0; i < 16; i++) begin
         n = s + 32'(i);
         r = ref_count(longint'(n), 32, 16);
         exp_cnt[i] = r.cnt;
         if (r.cnt > exp_max) begin
            exp_max = r.cnt;
            exp_idx = i;
         end
         if (r.ovf) exp_ovf = 1;
      end
   endtask

   // ---------------- check helpers ----------------
   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, exp);
   endtask

   task automatic start_main(input logic [31:0] s);
      @(negedge clk);
      m_start = s;
      m_go    = 1'b1;
      @(negedge clk);
      m_go    = 1'b0;
      check("busy_after_go", longint'(m_busy), 1);
      check("done_dropped_after_go", longint'(m_done), 0);
   endtask

   task automatic wait_main_done(input int budget);
      int c;
      c = 0;
      while (!m_done && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("main_done_within_budget", longint'(m_done), 1);
   endtask

   task automatic check_main(input string tag);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         m_rd_addr = 4'(i);
         @(negedge clk);
         check($sformatf("%s_rd%0d", tag, i), longint'(m_rd_data), exp_cnt[i]);
      end
      check({tag, "_max_count"}, longint'(m_max_count), exp_max);
      check({tag, "_max_index"}, longint'(m_max_index), exp_idx);
      check({tag, "_ovf"}, longint'(m_ovf), exp_ovf);
      check({tag, "_done"}, longint'(m_done), 1);
      check({tag, "_busy"}, longint'(m_busy), 0);
   endtask

   function automatic bit group_done();
      return t_done[0] && t_done[1] && t_done[2] && ov_done && wr_done && sat_done;
   endfunction

   function automatic int get_rd(input int inst);
      case (inst)
         0: return int'(t_rd[0]);
         1: return int'(t_rd[1]);
         2: return int'(t_rd[2]);
         3: return int'(ov_rd);
         4: return int'(wr_rd);
         default: return int'(sat_rd);
      endcase
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      int inst;
      int idx;
      int exp;
   } vec_t;

   vec_t  vecs [18];
   string inst_name [6];
   int    spec_start1 [16];

   initial begin
      mres_t r;
      int    c;
      int    pre_max;

      inst_name = '{"tie_nch1", "tie_nch2", "tie_nch4", "ovf8", "wrap8", "sat4"};
      spec_start1 = '{1, 2, 8, 3, 6, 9, 17, 4, 20, 7, 15, 10, 10, 18, 18, 5};
      for (int k = 0; k < 3; k++) begin
         vecs[4*k + 0] = '{k, 0, 10};
         vecs[4*k + 1] = '{k, 1, 10};
         vecs[4*k + 2] = '{k, 2, 18};
         vecs[4*k + 3] = '{k, 3, 18};
      end
      vecs[12] = '{3, 0, 65535};
      vecs[13] = '{3, 1, 19};
      vecs[14] = '{4, 0, 65535};
      vecs[15] = '{4, 1, 0};
      vecs[16] = '{5, 0, 15};
      vecs[17] = '{5, 1, 4};

      reset     = 1'b1;
      m_go      = 1'b0;
      m_start   = '0;
      m_rd_addr = '0;
      g_go      = 1'b0;
      rd_idx    = '0;
      t_start   = 32'd12;
      ov_start  = 8'd27;
      wr_start  = 8'd255;
      sat_start = 32'd7;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_busy", longint'(m_busy), 0);
      check("reset_done", longint'(m_done), 0);
      check("reset_rd_data", longint'(m_rd_data), 0);
      check("reset_max_count", longint'(m_max_count), 0);
      check("reset_max_index", longint'(m_max_index), 0);
      check("reset_ovf", longint'(m_ovf), 0);
      reset = 1'b0;

      // Small-parameter group: ties across NCH, overflow, wrap to zero, saturation
      @(negedge clk);
      g_go = 1'b1;
      @(negedge clk);
      g_go = 1'b0;
      c = 0;
      while (!group_done() && c < 5000) begin
         @(negedge clk);
         c++;
      end
      check("group_done_within_budget", longint'(group_done()), 1);
      foreach (vecs[v]) begin
         @(negedge clk);
         rd_idx = 8'(vecs[v].idx);
         @(negedge clk);
         check($sformatf("%s_rd%0d", inst_name[vecs[v].inst], vecs[v].idx),
               longint'(get_rd(vecs[v].inst)), vecs[v].exp);
      end
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s_max_count", inst_name[k]), longint'(t_max[k]), 18);
         check($sformatf("%s_max_index", inst_name[k]), longint'(t_midx[k]), 2);
         check($sformatf("%s_ovf", inst_name[k]), longint'(t_ovf[k]), 0);
      end
      check("ovf8_ovf", longint'(ov_ovf), 1);
      check("wrap8_ovf", longint'(wr_ovf), 1);
      check("sat4_ovf", longint'(sat_ovf), 0);
      // Remaining 8-bit words against the model
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         rd_idx = 8'(i);
         @(negedge clk);
         r = ref_count(longint'(8'(8'd27 + 8'(i))), 8, 16);
         check($sformatf("ovf8_model_rd%0d", i), longint'(ov_rd), r.cnt);
      end

      // Main run, start=1: expected values taken from the written-out table
      foreach (spec_start1[i]) exp_cnt[i] = spec_start1[i];
      exp_max = 20;
      exp_idx = 8;
      exp_ovf = 0;
      start_main(32'd1);
      wait_main_done(20000);
      check_main("start1");

      // go pulsed mid-run with a different start is ignored
      start_main(32'd1);
      repeat (5) @(negedge clk);
      m_start = 32'd500;
      m_go    = 1'b1;
      @(negedge clk);
      m_go    = 1'b0;
      check("busy_during_ignored_go", longint'(m_busy), 1);
      wait_main_done(20000);
      check_main("ignore_go");

      // Reset asserted mid-RUN of the second batch
      model_main(32'd27);
      pre_max = exp_max;
      start_main(32'd27);
      repeat (140) @(negedge clk);
      check("pre_reset_busy", longint'(m_busy), 1);
      check("pre_reset_max_count", longint'(m_max_count), pre_max);
      #2 reset = 1'b1;
      #1;
      check("abort_busy", longint'(m_busy), 0);
      check("abort_done", longint'(m_done), 0);
      check("abort_max_count", longint'(m_max_count), 0);
      check("abort_max_index", longint'(m_max_index), 0);
      check("abort_ovf", longint'(m_ovf), 0);
      check("abort_rd_data", longint'(m_rd_data), 0);
      @(negedge clk);
      reset = 1'b0;

      // Fresh run after abort reproduces the start=1 results
      foreach (spec_start1[i]) exp_cnt[i] = spec_start1[i];
      exp_max = 20;
      exp_idx = 8;
      exp_ovf = 0;
      start_main(32'd1);
      wait_main_done(20000);
      check_main("after_abort");

      // Random runs against the reference model
      for (int run = 0; run < 6; run++) begin
         logic [31:0] s;
         case (run % 3)
            0:       s = $urandom();
            1:       s = 32'($urandom_range(1, 5000));
            default: s = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         endcase
         model_main(s);
         start_main(s);
         wait_main_done(20000);
         check_main($sformatf("rand%0d", run));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
